// File: rtl/ids_bus_pkg.sv
// Shared types for the IDS bus datapath: read-owner encoding and default bus widths.
package ids_bus_pkg;

   localparam int AW_DEFAULT = 12;
   localparam int DW_DEFAULT = 32;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_SPI  = 2'd1,
      OWN_DMEM = 2'd2,
      OWN_DMA  = 2'd3
   } owner_e;

endpackage

// File: rtl/ids_rsp_hold.sv
// Per-master read response stage: passes memory data through on the response cycle
// and holds it afterwards until that master's next read completes.
module ids_rsp_hold #(
   parameter int DW = 32
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_fire,
   input  logic [DW-1:0] i_mem_rdata,
   output logic          o_rvalid,
   output logic [DW-1:0] o_rdata
);

   logic [DW-1:0] rdata_q;
   logic [DW-1:0] rdata_d;

   always_comb begin
      rdata_d = rdata_q;
      if (i_fire) begin
         rdata_d = i_mem_rdata;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   // Bypass so the master sees the data in the same cycle rvalid is high.
   assign o_rvalid = i_fire;
   assign o_rdata  = i_fire ? i_mem_rdata : rdata_q;

endmodule

// File: rtl/ids_bus_mux.sv
// Steers the granted master onto the shared memory port and routes each read
// response back to the master that issued it, independent of later grant changes.
module ids_bus_mux
   import ids_bus_pkg::*;
#(
   parameter int AW = AW_DEFAULT,
   parameter int DW = DW_DEFAULT
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_gnt_spi,
   input  logic            i_gnt_dmem,
   input  logic            i_gnt_dma,
   input  logic            i_spi_req,
   input  logic            i_spi_we,
   input  logic [AW-1:0]   i_spi_addr,
   input  logic [DW-1:0]   i_spi_wdata,
   input  logic [DW/8-1:0] i_spi_be,
   input  logic            i_dmem_req,
   input  logic            i_dmem_we,
   input  logic [AW-1:0]   i_dmem_addr,
   input  logic [DW-1:0]   i_dmem_wdata,
   input  logic [DW/8-1:0] i_dmem_be,
   input  logic            i_dma_req,
   input  logic            i_dma_we,
   input  logic [AW-1:0]   i_dma_addr,
   input  logic [DW-1:0]   i_dma_wdata,
   input  logic [DW/8-1:0] i_dma_be,
   output logic [DW-1:0]   o_spi_rdata,
   output logic            o_spi_rvalid,
   output logic            o_spi_ack,
   output logic [DW-1:0]   o_dmem_rdata,
   output logic            o_dmem_rvalid,
   output logic            o_dmem_ack,
   output logic [DW-1:0]   o_dma_rdata,
   output logic            o_dma_rvalid,
   output logic            o_dma_ack,
   output logic            o_mem_en,
   output logic            o_mem_we,
   output logic [AW-1:0]   o_mem_addr,
   output logic [DW-1:0]   o_mem_wdata,
   output logic [DW/8-1:0] o_mem_be,
   input  logic [DW-1:0]   i_mem_rdata,
   output logic            o_bus_busy
);

   owner_e sel_owner;
   owner_e rd_owner_q;
   owner_e rd_owner_d;
   logic   rd_pend_q;
   logic   rd_pend_d;
   logic   err_multi_gnt_q;
   logic   err_multi_gnt_d;
   logic   multi_gnt;
   logic   rd_accept;

   // Fixed priority SPI > DMEM > DMA only matters when the arbiter misbehaves.
   always_comb begin
      sel_owner   = OWN_NONE;
      o_mem_en    = 1'b0;
      o_mem_we    = 1'b0;
      o_mem_addr  = '0;
      o_mem_wdata = '0;
      o_mem_be    = '0;
      if (i_gnt_spi && i_spi_req) begin
         sel_owner = OWN_SPI;
      end else if (i_gnt_dmem && i_dmem_req) begin
         sel_owner = OWN_DMEM;
      end else if (i_gnt_dma && i_dma_req) begin
         sel_owner = OWN_DMA;
      end
      case (sel_owner)
         OWN_SPI: begin
            o_mem_en    = 1'b1;
            o_mem_we    = i_spi_we;
            o_mem_addr  = i_spi_addr;
            o_mem_wdata = i_spi_wdata;
            o_mem_be    = i_spi_be;
         end
         OWN_DMEM: begin
            o_mem_en    = 1'b1;
            o_mem_we    = i_dmem_we;
            o_mem_addr  = i_dmem_addr;
            o_mem_wdata = i_dmem_wdata;
            o_mem_be    = i_dmem_be;
         end
         OWN_DMA: begin
            o_mem_en    = 1'b1;
            o_mem_we    = i_dma_we;
            o_mem_addr  = i_dma_addr;
            o_mem_wdata = i_dma_wdata;
            o_mem_be    = i_dma_be;
         end
         default: begin
         end
      endcase
   end

   assign o_spi_ack  = (sel_owner == OWN_SPI);
   assign o_dmem_ack = (sel_owner == OWN_DMEM);
   assign o_dma_ack  = (sel_owner == OWN_DMA);

   assign rd_accept = o_mem_en & ~o_mem_we;
   assign multi_gnt = (i_gnt_spi & i_gnt_dmem) | (i_gnt_spi & i_gnt_dma) | (i_gnt_dmem & i_gnt_dma);

   // The owner is captured at accept time so a grant change cannot redirect the response.
   always_comb begin
      rd_pend_d       = rd_accept;
      rd_owner_d      = rd_accept ? sel_owner : OWN_NONE;
      err_multi_gnt_d = err_multi_gnt_q | multi_gnt;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rd_pend_q       <= 1'b0;
         rd_owner_q      <= OWN_NONE;
         err_multi_gnt_q <= 1'b0;
      end else begin
         rd_pend_q       <= rd_pend_d;
         rd_owner_q      <= rd_owner_d;
         err_multi_gnt_q <= err_multi_gnt_d;
      end
   end

   assign o_bus_busy = rd_pend_q;

   ids_rsp_hold #(.DW(DW)) u_spi_rsp (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_fire      (rd_pend_q && (rd_owner_q == OWN_SPI)),
      .i_mem_rdata (i_mem_rdata),
      .o_rvalid    (o_spi_rvalid),
      .o_rdata     (o_spi_rdata)
   );

   ids_rsp_hold #(.DW(DW)) u_dmem_rsp (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_fire      (rd_pend_q && (rd_owner_q == OWN_DMEM)),
      .i_mem_rdata (i_mem_rdata),
      .o_rvalid    (o_dmem_rvalid),
      .o_rdata     (o_dmem_rdata)
   );

   ids_rsp_hold #(.DW(DW)) u_dma_rsp (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_fire      (rd_pend_q && (rd_owner_q == OWN_DMA)),
      .i_mem_rdata (i_mem_rdata),
      .o_rvalid    (o_dma_rvalid),
      .o_rdata     (o_dma_rdata)
   );

endmodule

// File: tb/tb_ids_bus_mux.sv
// Self-checking bench for ids_bus_mux: directed scenarios plus randomized traffic
// against a behavioural model of master selection and in-order read responses.
module tb_ids_bus_mux;

   logic        clk;
   logic        rst_n;
   logic        gnt   [3];
   logic        req   [3];
   logic        we    [3];
   logic [11:0] addr  [3];
   logic [31:0] wdata [3];
   logic [3:0]  be    [3];
   logic [31:0] mem_rdata;

   logic [31:0] spi_rdata, dmem_rdata, dma_rdata;
   logic        spi_rvalid, dmem_rvalid, dma_rvalid;
   logic        spi_ack, dmem_ack, dma_ack;
   logic        mem_en, mem_we, bus_busy;
   logic [11:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;

   logic [31:0] rdata  [3];
   logic        rvalid [3];
   logic        ack    [3];

   int errors;
   int checks;

   assign rdata[0]  = spi_rdata;
   assign rdata[1]  = dmem_rdata;
   assign rdata[2]  = dma_rdata;
   assign rvalid[0] = spi_rvalid;
   assign rvalid[1] = dmem_rvalid;
   assign rvalid[2] = dma_rvalid;
   assign ack[0]    = spi_ack;
   assign ack[1]    = dmem_ack;
   assign ack[2]    = dma_ack;

   ids_bus_mux dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_gnt_spi     (gnt[0]),
      .i_gnt_dmem    (gnt[1]),
      .i_gnt_dma     (gnt[2]),
      .i_spi_req     (req[0]),
      .i_spi_we      (we[0]),
      .i_spi_addr    (addr[0]),
      .i_spi_wdata   (wdata[0]),
      .i_spi_be      (be[0]),
      .i_dmem_req    (req[1]),
      .i_dmem_we     (we[1]),
      .i_dmem_addr   (addr[1]),
      .i_dmem_wdata  (wdata[1]),
      .i_dmem_be     (be[1]),
      .i_dma_req     (req[2]),
      .i_dma_we      (we[2]),
      .i_dma_addr    (addr[2]),
      .i_dma_wdata   (wdata[2]),
      .i_dma_be      (be[2]),
      .o_spi_rdata   (spi_rdata),
      .o_spi_rvalid  (spi_rvalid),
      .o_spi_ack     (spi_ack),
      .o_dmem_rdata  (dmem_rdata),
      .o_dmem_rvalid (dmem_rvalid),
      .o_dmem_ack    (dmem_ack),
      .o_dma_rdata   (dma_rdata),
      .o_dma_rvalid  (dma_rvalid),
      .o_dma_ack     (dma_ack),
      .o_mem_en      (mem_en),
      .o_mem_we      (mem_we),
      .o_mem_addr    (mem_addr),
      .o_mem_wdata   (mem_wdata),
      .o_mem_be      (mem_be),
      .i_mem_rdata   (mem_rdata),
      .o_bus_busy    (bus_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic idle_inputs();
      for (int i = 0; i < 3; i++) begin
         gnt[i]   = 1'b0;
         req[i]   = 1'b0;
         we[i]    = 1'b0;
         addr[i]  = '0;
         wdata[i] = '0;
         be[i]    = '0;
      end
      mem_rdata = '0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle_inputs();
      #3;
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (rvalid[i] !== 1'b0) begin
               errors++;
               $display("[TB] FAIL reset_rvalid[%0d]: got %0b expected 0", i, rvalid[i]);
            end
            checks++;
            if (rdata[i] !== 32'h0) begin
               errors++;
               $display("[TB] FAIL reset_rdata[%0d]: got %h expected 0", i, rdata[i]);
            end
         end
         checks++;
         if (mem_en !== 1'b0 || bus_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_en_busy: got en=%0b busy=%0b expected 0/0", mem_en, bus_busy);
         end
         next_cycle();
      end
      rst_n = 1'b1;
      next_cycle();
   endtask

   task automatic test_dmem_read();
      idle_inputs();
      gnt[1] = 1'b1; req[1] = 1'b1; we[1] = 1'b0; addr[1] = 12'h010;
      #1;
      checks++;
      if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 12'h010 || dmem_ack !== 1'b1) begin
         errors++;
         $display("[TB] FAIL dmem_read_port: got en=%0b we=%0b addr=%h ack=%0b expected 1/0/010/1",
                  mem_en, mem_we, mem_addr, dmem_ack);
      end
      next_cycle();
      idle_inputs();
      mem_rdata = 32'hDEADBEEF;
      #1;
      checks++;
      if (dmem_rvalid !== 1'b1 || dmem_rdata !== 32'hDEADBEEF) begin
         errors++;
         $display("[TB] FAIL dmem_read_rsp: got rvalid=%0b rdata=%h expected 1/deadbeef", dmem_rvalid, dmem_rdata);
      end
      checks++;
      if (spi_rvalid !== 1'b0 || dma_rvalid !== 1'b0 || bus_busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL dmem_read_others: got spi=%0b dma=%0b busy=%0b expected 0/0/1",
                  spi_rvalid, dma_rvalid, bus_busy);
      end
      next_cycle();
      mem_rdata = 32'h0BAD0BAD;
      #1;
      checks++;
      if (dmem_rvalid !== 1'b0 || dmem_rdata !== 32'hDEADBEEF || bus_busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL dmem_read_hold: got rvalid=%0b rdata=%h busy=%0b expected 0/deadbeef/0",
                  dmem_rvalid, dmem_rdata, bus_busy);
      end
      next_cycle();
   endtask

   task automatic test_grant_switch();
      idle_inputs();
      gnt[2] = 1'b1; req[2] = 1'b1; addr[2] = 12'h020;
      next_cycle();
      idle_inputs();
      gnt[1] = 1'b1; req[1] = 1'b1; we[1] = 1'b1; addr[1] = 12'h030; wdata[1] = 32'hCAFEF00D; be[1] = 4'hF;
      mem_rdata = 32'h12345678;
      #1;
      checks++;
      if (dma_rvalid !== 1'b1 || dma_rdata !== 32'h12345678 || dmem_rvalid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL switch_rsp: got dma_rvalid=%0b dma_rdata=%h dmem_rvalid=%0b expected 1/12345678/0",
                  dma_rvalid, dma_rdata, dmem_rvalid);
      end
      checks++;
      if (mem_we !== 1'b1 || mem_addr !== 12'h030 || dmem_ack !== 1'b1 || dma_ack !== 1'b0) begin
         errors++;
         $display("[TB] FAIL switch_write: got we=%0b addr=%h dmem_ack=%0b dma_ack=%0b expected 1/030/1/0",
                  mem_we, mem_addr, dmem_ack, dma_ack);
      end
      next_cycle();
      idle_inputs();
      #1;
      checks++;
      if (dmem_rvalid !== 1'b0 || dma_rvalid !== 1'b0 || dma_rdata !== 32'h12345678 || bus_busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL switch_after: got dmem_rv=%0b dma_rv=%0b dma_rdata=%h busy=%0b expected 0/0/12345678/0",
                  dmem_rvalid, dma_rvalid, dma_rdata, bus_busy);
      end
      next_cycle();
   endtask

   task automatic test_back_to_back();
      idle_inputs();
      gnt[1] = 1'b1; req[1] = 1'b1; addr[1] = 12'h100;
      next_cycle();
      idle_inputs();
      gnt[2] = 1'b1; req[2] = 1'b1; addr[2] = 12'h200;
      mem_rdata = 32'h0000000A;
      #1;
      checks++;
      if (dmem_rvalid !== 1'b1 || dmem_rdata !== 32'hA || dma_rvalid !== 1'b0 || bus_busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL b2b_first: got dmem_rv=%0b dmem_rdata=%h dma_rv=%0b busy=%0b expected 1/a/0/1",
                  dmem_rvalid, dmem_rdata, dma_rvalid, bus_busy);
      end
      next_cycle();
      idle_inputs();
      mem_rdata = 32'h0000000B;
      #1;
      checks++;
      if (dma_rvalid !== 1'b1 || dma_rdata !== 32'hB || dmem_rvalid !== 1'b0 || bus_busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL b2b_second: got dma_rv=%0b dma_rdata=%h dmem_rv=%0b busy=%0b expected 1/b/0/1",
                  dma_rvalid, dma_rdata, dmem_rvalid, bus_busy);
      end
      checks++;
      if (dmem_rdata !== 32'hA) begin
         errors++;
         $display("[TB] FAIL b2b_hold: got dmem_rdata=%h expected a", dmem_rdata);
      end
      next_cycle();
      #1;
      checks++;
      if (bus_busy !== 1'b0 || dma_rvalid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL b2b_idle: got busy=%0b dma_rv=%0b expected 0/0", bus_busy, dma_rvalid);
      end
      next_cycle();
   endtask

   task automatic test_write();
      idle_inputs();
      gnt[0] = 1'b1; req[0] = 1'b1; we[0] = 1'b1; addr[0] = 12'h004;
      wdata[0] = 32'h55AA55AA; be[0] = 4'b0011;
      #1;
      checks++;
      if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 12'h004 ||
          mem_wdata !== 32'h55AA55AA || mem_be !== 4'b0011 || spi_ack !== 1'b1) begin
         errors++;
         $display("[TB] FAIL write_port: got en=%0b we=%0b addr=%h wdata=%h be=%b ack=%0b expected 1/1/004/55aa55aa/0011/1",
                  mem_en, mem_we, mem_addr, mem_wdata, mem_be, spi_ack);
      end
      next_cycle();
      idle_inputs();
      mem_rdata = 32'hFFFFFFFF;
      #1;
      checks++;
      if (spi_rvalid !== 1'b0 || dmem_rvalid !== 1'b0 || dma_rvalid !== 1'b0 || bus_busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL write_no_rsp: got rv=%0b%0b%0b busy=%0b expected 000/0",
                  spi_rvalid, dmem_rvalid, dma_rvalid, bus_busy);
      end
      next_cycle();
   endtask

   task automatic test_illegal_grant();
      idle_inputs();
      gnt[0] = 1'b1; req[0] = 1'b1; addr[0] = 12'h0AA;
      gnt[2] = 1'b1; req[2] = 1'b1; addr[2] = 12'h0BB;
      #1;
      checks++;
      if (mem_addr !== 12'h0AA || spi_ack !== 1'b1 || dma_ack !== 1'b0) begin
         errors++;
         $display("[TB] FAIL illegal_select: got addr=%h spi_ack=%0b dma_ack=%0b expected 0aa/1/0",
                  mem_addr, spi_ack, dma_ack);
      end
      next_cycle();
      idle_inputs();
      checks++;
      if (dut.err_multi_gnt_q !== 1'b1 || bus_busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL illegal_flag: got err=%0b busy=%0b expected 1/1", dut.err_multi_gnt_q, bus_busy);
      end
      mem_rdata = 32'h77777777;
      rst_n = 1'b0;
      #1;
      checks++;
      if (spi_rvalid !== 1'b0 || bus_busy !== 1'b0 || dut.err_multi_gnt_q !== 1'b0) begin
         errors++;
         $display("[TB] FAIL illegal_reset: got spi_rv=%0b busy=%0b err=%0b expected 0/0/0",
                  spi_rvalid, bus_busy, dut.err_multi_gnt_q);
      end
      next_cycle();
      rst_n = 1'b1;
      for (int k = 0; k < 2; k++) begin
         next_cycle();
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (rvalid[i] !== 1'b0 || rdata[i] !== 32'h0) begin
               errors++;
               $display("[TB] FAIL illegal_release[%0d]: got rv=%0b rdata=%h expected 0/0", i, rvalid[i], rdata[i]);
            end
         end
      end
   endtask

   task automatic test_random();
      logic [31:0] held [3];
      int pend;
      int sel;
      int r;
      logic        exp_we;
      logic [11:0] exp_addr;
      logic [31:0] exp_wdata;
      logic [3:0]  exp_be;
      pend = -1;
      for (int i = 0; i < 3; i++) held[i] = '0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         r = $urandom_range(0, 9);
         for (int i = 0; i < 3; i++) begin
            gnt[i]   = (r >= 9) ? 1'($urandom_range(0, 1)) : (r >= 2 && (r % 3) == i);
            req[i]   = ($urandom_range(0, 3) != 0);
            we[i]    = ($urandom_range(0, 2) == 0);
            addr[i]  = 12'($urandom);
            wdata[i] = $urandom;
            be[i]    = 4'($urandom);
         end
         mem_rdata = $urandom;
         #1;
         sel = -1;
         for (int i = 2; i >= 0; i--) begin
            if (gnt[i] && req[i]) sel = i;
         end
         exp_we    = (sel >= 0) ? we[sel]    : 1'b0;
         exp_addr  = (sel >= 0) ? addr[sel]  : 12'h0;
         exp_wdata = (sel >= 0) ? wdata[sel] : 32'h0;
         exp_be    = (sel >= 0) ? be[sel]    : 4'h0;
         checks++;
         if (mem_en !== (sel >= 0) || mem_we !== exp_we || mem_addr !== exp_addr ||
             mem_wdata !== exp_wdata || mem_be !== exp_be) begin
            errors++;
            $display("[TB] FAIL rand_port cyc%0d: got en=%0b we=%0b addr=%h wdata=%h be=%h expected %0b/%0b/%h/%h/%h",
                     cyc, mem_en, mem_we, mem_addr, mem_wdata, mem_be, (sel >= 0), exp_we, exp_addr, exp_wdata, exp_be);
         end
         checks++;
         if (bus_busy !== (pend >= 0)) begin
            errors++;
            $display("[TB] FAIL rand_busy cyc%0d: got %0b expected %0b", cyc, bus_busy, (pend >= 0));
         end
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (ack[i] !== (i == sel) || rvalid[i] !== (i == pend) ||
                rdata[i] !== ((i == pend) ? mem_rdata : held[i])) begin
               errors++;
               $display("[TB] FAIL rand_master[%0d] cyc%0d: got ack=%0b rv=%0b rdata=%h expected %0b/%0b/%h",
                        i, cyc, ack[i], rvalid[i], rdata[i], (i == sel), (i == pend),
                        (i == pend) ? mem_rdata : held[i]);
            end
         end
         if (pend >= 0) held[pend] = mem_rdata;
         pend = (sel >= 0 && !we[sel]) ? sel : -1;
         next_cycle();
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst_n  = 1'b0;
      idle_inputs();
      test_reset();
      test_dmem_read();
      test_grant_switch();
      test_back_to_back();
      test_write();
      test_illegal_grant();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ids_bus_mux.md
# ids_bus_mux

Datapath stage directly downstream of the three-master shared-bus arbiter. It takes the one-hot grants (SPI, DMEM/RV core, DMA) and steers the granted master's request onto the single shared memory port. It returns read data to the master that issued the read, tracking the one-cycle memory read latency so that a grant change never misroutes a response.

## Interface
- AW, 12: word/byte address width on all request and memory ports.
- DW, 32: data width; byte-enable width is DW/8.

Ports:
- i_clk  in  1  single clock, rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_gnt_spi / i_gnt_dmem / i_gnt_dma  in  1 each  grants from arbiter, registered there, nominally one-hot or all-zero.
- i_{spi,dmem,dma}_req  in  1  master request strobe (the same signal also drives the arbiter request).
- i_{spi,dmem,dma}_we  in  1  1 = write, 0 = read.
- i_{spi,dmem,dma}_addr  in  AW  address.
- i_{spi,dmem,dma}_wdata  in  DW  write data.
- i_{spi,dmem,dma}_be  in  DW/8  byte enables.
- o_{spi,dmem,dma}_rdata  out  DW  read data, held until that master's next read completes.
- o_{spi,dmem,dma}_rvalid  out  1  one-cycle pulse, read data valid.
- o_{spi,dmem,dma}_ack  out  1  request accepted this cycle (combinational: grant & req).
- o_mem_en  out  1  memory access strobe.
- o_mem_we  out  1  memory write enable.
- o_mem_addr  out  AW
- o_mem_wdata  out  DW
- o_mem_be  out  DW/8
- i_mem_rdata  in  DW  memory read data, valid the cycle after a read with o_mem_en=1.
- o_bus_busy  out  1  a read is in flight (registered).

## Operation
- Select: the active master is the granted master whose req is high. If more than one grant is high (illegal), the priority is SPI > DMEM > DMA, and a sticky internal flag err_multi_gnt is set (cleared only by reset; used for assertion only).
- Memory port is combinational from the selected master: o_mem_en = selected req; we/addr/wdata/be are copied from it. With no selection: en=0, we=0, addr/wdata/be=0.
- o_<m>_ack = gnt_<m> & req_<m> & selected.
- Read tracking: on an accepted read (en & ~we), capture rd_owner ∈ {NONE, SPI, DMEM, DMA} and set rd_pend=1. In the next cycle, route i_mem_rdata into o_<owner>_rdata, pulse o_<owner>_rvalid, and clear rd_pend, unless a new read is accepted in that same cycle, in which case rd_pend stays 1 with the new owner.
- Back-to-back reads from any mix of masters are supported: one read issued per cycle, one response per cycle, in order.
- Writes produce no rvalid and do not disturb rd_owner.
- Grant drop or switch while rd_pend=1: the response still goes to the captured owner. Grant state has no influence on the response path.
- Unselected masters see rvalid=0. Their rdata is held.

## Timing
- Request to memory: 0 cycles (combinational).
- Read: accept at cycle N, then rvalid and rdata at cycle N+1 (rdata is registered from i_mem_rdata at the end of N+1, so it is visible as a held value from N+2; rvalid is registered and asserted during N+1 alongside the combinational rdata bypass). Decided: o_<m>_rdata is a mux of i_mem_rdata when that master's rvalid=1, otherwise the held register.
- Reset values: rd_pend=0, rd_owner=NONE, all rvalid=0, all held rdata=0, o_bus_busy=0, err_multi_gnt=0.
- Async reset asserted mid-read: the response is dropped, and no rvalid occurs after reset release.
- o_bus_busy = rd_pend.

## Structure
- Shared package ids_bus_pkg: owner enum (OWN_NONE, OWN_SPI, OWN_DMEM, OWN_DMA; 2 bits), and localparams for AW/DW defaults.
- One sub-module, ids_rsp_hold: per-master rdata holding register plus rvalid pulse, instantiated three times.
- The arbiter and this mux are instantiated side by side in the bus top.

## Test plan
- Reset: hold i_rst_n=0 → all rvalid=0, o_mem_en=0, o_bus_busy=0, all rdata=0.
- DMEM read: gnt_dmem=1, req=1, we=0, addr=0x010, mem returns 0xDEADBEEF → o_mem_addr=0x010 at N; o_dmem_rvalid=1 and rdata=0xDEADBEEF at N+1; spi/dma rvalid stay 0.
- Grant switch mid-read: DMA read of 0x020 at N, grant moves to DMEM at N+1 with a write → mem returns 0x12345678 → o_dma_rvalid=1, o_dma_rdata=0x12345678; o_dmem_rvalid=0.
- Back-to-back reads from DMEM then DMA at N and N+1 (data 0xA, 0xB) → o_dmem_rvalid at N+1 with 0xA, o_dma_rvalid at N+2 with 0xB; o_bus_busy high at N+1 and N+2.
- Write: SPI write addr 0x004, wdata 0x55AA55AA, be=4'b0011 → o_mem_we=1 and fields match at N; no rvalid follows.
- Illegal grant: gnt_spi=gnt_dma=1, both requesting → the SPI request drives the memory port, err_multi_gnt=1, o_dma_ack=0; async reset mid-read then → no rvalid after release.
